// File: rtl/product_serializer_pkg.sv
// Shared types and constants for the product register serializer.
package product_serializer_pkg;

    localparam int unsigned DEFAULT_DATA_W       = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/product_serializer_bit_timer.sv
// Modulo-CLKS_PER_BIT bit timer; tick marks the last cycle of a bit period.
module product_serializer_bit_timer
    import product_serializer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = width_of(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == TERMINAL);

    // Wrap on the terminal count so each bit period restarts from zero.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/product_serializer.sv
// Parallel-to-serial UART-style framer: start bit, DATA_W data bits LSB-first, stop bit.
module product_serializer
    import product_serializer_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = width_of(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              timer_restart;

    // Timer is parked at zero while idle so the start bit gets a full period.
    assign timer_restart = (state_q == ST_IDLE);

    product_serializer_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .clr    (clr),
        .restart(timer_restart),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_START;
                    shift_d = in;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers track the FSM.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_product_serializer.sv
// Bench for product_serializer: two instances (4 and 1 clocks per bit) checked by a frame monitor.
module tb_product_serializer;

    logic       clk;
    logic       clr;
    logic [7:0] in0, in1;
    logic       load0, load1;
    logic [1:0] ready_w, tx_w, busy_w, done_w;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q0 [$];
    logic [9:0] exp_q1 [$];

    product_serializer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .clr(clr), .in(in0), .load(load0),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    product_serializer #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .clr(clr), .in(in1), .load(load1),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame monitor: rebuilds each frame from tx while busy and compares against the scoreboard.
    int         cnt   [2];
    bit         coll  [2];
    bit         drop  [2];
    logic [9:0] got   [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int cpb;
            int b;
            logic [9:0] exp_f;
            cpb = (k == 0) ? 4 : 1;
            if (!clr) begin
                coll[k] = 1'b0;
                cnt[k]  = 0;
                drop[k] = 1'b0;
            end else begin
                if (drop[k]) begin
                    chk($sformatf("done_drop%0d", k), int'(done_w[k]), 0);
                    drop[k] = 1'b0;
                end else if (done_w[k] && !(coll[k] && !busy_w[k])) begin
                    chk($sformatf("stray_done%0d", k), int'(done_w[k]), 0);
                end
                if (busy_w[k]) begin
                    b = cnt[k] / cpb;
                    if (b < 10) begin
                        if (cnt[k] % cpb == 0) got[k][b] = tx_w[k];
                        else chk($sformatf("bit_hold%0d", k), int'(tx_w[k]), int'(got[k][b]));
                    end
                    cnt[k]++;
                    coll[k] = 1'b1;
                end else if (coll[k]) begin
                    chk($sformatf("busy_len%0d", k), cnt[k], 10 * cpb);
                    chk($sformatf("done_pulse%0d", k), int'(done_w[k]), 1);
                    chk($sformatf("ready_back%0d", k), int'(ready_w[k]), 1);
                    if (k == 0 && exp_q0.size() > 0) begin
                        exp_f = exp_q0.pop_front();
                        chk("frame0", int'(got[k]), int'(exp_f));
                    end else if (k == 1 && exp_q1.size() > 0) begin
                        exp_f = exp_q1.pop_front();
                        chk("frame1", int'(got[k]), int'(exp_f));
                    end else begin
                        chk($sformatf("unexpected_frame%0d", k), int'(got[k]), 0);
                    end
                    coll[k] = 1'b0;
                    cnt[k]  = 0;
                    drop[k] = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_w[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[k]) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_w[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[k]) chk("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic [9:0] f, input bit push);
        wait_ready(k);
        if (k == 0) begin
            in0 = d; load0 = 1'b1;
            if (push) exp_q0.push_back(f);
        end else begin
            in1 = d; load1 = 1'b1;
            if (push) exp_q1.push_back(f);
        end
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
        chk("accept_busy", int'(busy_w[k]), 1);
        chk("accept_ready", int'(ready_w[k]), 0);
        chk("accept_tx", int'(tx_w[k]), 0);
    endtask

    typedef struct {
        int         k;
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int busy_cnt, ready_cnt, dones, n;
        bit prev_done;

        vecs[0] = '{k: 0, data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{k: 0, data: 8'h00, frame: 10'h200};
        vecs[2] = '{k: 0, data: 8'hC3, frame: 10'h386};
        vecs[3] = '{k: 1, data: 8'h01, frame: 10'h202};
        vecs[4] = '{k: 1, data: 8'hA3, frame: 10'h346};

        clr = 1'b0; in0 = 8'h00; in1 = 8'h00; load0 = 1'b0; load1 = 1'b0;

        // Reset held, then released; line must stay idle.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", int'(tx_w[0]), 1);
            chk("rst_ready", int'(ready_w[0]), 1);
            chk("rst_busy", int'(busy_w[0]), 0);
            chk("rst_done", int'(done_w[0]), 0);
        end
        #2 clr = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_tx", int'(tx_w[0]), 1);
            chk("idle_ready", int'(ready_w[0]), 1);
            chk("idle_busy", int'(busy_w[0]), 0);
            chk("idle_done1", int'(done_w[1]), 0);
        end

        // Single frames from the table on both instances.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].k, vecs[i].data, vecs[i].frame, 1'b1);
            wait_idle(vecs[i].k);
        end

        // Mid-frame load and data changes must be ignored.
        send(0, 8'hA3, 10'h346, 1'b1);
        repeat (10) @(negedge clk);
        in0 = 8'hFF;
        load0 = 1'b1;
        repeat (20) @(negedge clk);
        chk("midframe_ready", int'(ready_w[0]), 0);
        load0 = 1'b0;
        wait_idle(0);

        // Back-to-back frames with load held high.
        wait_ready(0);
        in0 = 8'h0F; load0 = 1'b1;
        exp_q0.push_back(10'h21E);
        exp_q0.push_back(10'h3E0);
        @(negedge clk);
        in0 = 8'hF0;
        busy_cnt = 0; ready_cnt = 0; dones = 0; prev_done = 1'b0; n = 0;
        while (dones < 2 && n < 200) begin
            if (prev_done) load0 = 1'b0;
            if (busy_w[0]) busy_cnt++;
            if (ready_w[0]) ready_cnt++;
            prev_done = done_w[0];
            if (done_w[0]) dones++;
            if (dones < 2) @(negedge clk);
            n++;
        end
        load0 = 1'b0;
        chk("b2b_dones", dones, 2);
        chk("b2b_busy", busy_cnt, 80);
        chk("b2b_ready", ready_cnt, 2);
        wait_idle(0);

        // Reset during data bit 3 abandons the frame; next load right after release.
        send(0, 8'hFF, 10'h3FE, 1'b0);
        repeat (17) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("abort_tx", int'(tx_w[0]), 1);
        chk("abort_ready", int'(ready_w[0]), 1);
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_done", int'(done_w[0]), 0);
        @(negedge clk);
        in0 = 8'h81; load0 = 1'b1;
        exp_q0.push_back(10'h302);
        #2 clr = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        chk("post_reset_accept", int'(busy_w[0]), 1);
        wait_idle(0);

        // One clock per bit on the second instance.
        send(1, 8'h01, 10'h202, 1'b1);
        wait_idle(1);

        chk("queue0_empty", exp_q0.size(), 0);
        chk("queue1_empty", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/product_serializer.md
Name: product_serializer

Overview:
- Reader end of the 8-bit product register path. Accepts a parallel word via a load/ready handshake and shifts it out on a single UART-style line.
- Frame is LSB-first: start bit (0), DATA_W data bits, stop bit (1).
- Sits after the product register in the multiplier datapath and drives the FPGA serial pin or the bench monitor.
- Each bit is held CLKS_PER_BIT clock cycles.

Parameters:
- DATA_W, 8, width of the parallel word and number of data bits per frame.
- CLKS_PER_BIT, 4, clock cycles per serial bit. Legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset. clr=0 forces the reset state immediately, independent of clk.
- in  input  DATA_W  parallel word to transmit; sampled only on the accept edge.
- load  input  1  request to transmit `in`.
- ready  output  1  high when a new word can be accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (clr=0): state=IDLE, tx=1, ready=1, busy=0, done=0, shift register=0, bit counter=0, timer=0. All outputs are registered.
- States:
  - IDLE: tx=1, ready=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0].
  - STOP: tx=1.
- Accept: on a rising edge where load=1 and ready=1, capture in into the shift register and go to START. After that edge: tx=0, ready=0, busy=1.
- Changes to in or load after the accept edge have no effect.
- load=1 while ready=0 is ignored. It is not queued.
- The bit timer counts 0..CLKS_PER_BIT-1 and raises tick on the terminal count. State advances only on tick.
- START + tick: go to DATA, bit index=0.
- DATA + tick:
  - Shift right by one.
  - If index=DATA_W-1, go to STOP.
  - Otherwise increment index.
- STOP + tick: go to IDLE.
  - In the cycle after this edge: ready=1, busy=0, done=1.
  - done drops the following cycle.
- Latency: accept edge to return to IDLE is exactly (DATA_W+2)*CLKS_PER_BIT cycles. busy is high for exactly that many cycles.
- Back-to-back frames:
  - load=1 in the first IDLE cycle (the done cycle) is accepted.
  - The next start bit follows the previous stop bit with zero idle gap.
- CLKS_PER_BIT=1: tick is permanently high, so the frame takes DATA_W+2 cycles.
- Reset mid-frame:
  - tx goes to 1 and ready to 1 asynchronously; no done pulse is produced.
  - The partial frame is abandoned.
  - The first edge after clr deasserts may accept a new word.
- The timer resets to 0 on every state transition, so every bit lasts exactly CLKS_PER_BIT cycles.

Decomposition:
- Shared include file multiplier_defs.vh:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - default data width 8.
- One sub-module, bit_timer:
  - parameter CLKS_PER_BIT; ports clk, clr, restart, tick;
  - modulo counter with async active-low clear.
- The counter width is derived from CLKS_PER_BIT with $clog2. A minimum width of 1 is enforced.

Test Plan:
1. Reset with clr=0 for 3 cycles, then release -> tx=1, ready=1, busy=0, done=0 throughout; no transitions on tx while load=0.
2. CLKS_PER_BIT=4, in=8'h55, load pulsed 1 cycle ->
   - tx levels per 4-cycle bit: 0 | 1,0,1,0,1,0,1,0 | 1;
   - busy high exactly 40 cycles;
   - done high for exactly 1 cycle at cycle 41 after accept.
3. in=8'hA3, then load=1 with in changed to 8'hFF during the frame ->
   - data bits 1,1,0,0,0,1,0,1 (LSB-first);
   - mid-frame load and in changes ignored.
4. load held high continuously with words 8'h0F then 8'hF0 (in updated on done) ->
   - two frames, second start bit begins the cycle after the first stop bit ends;
   - 80 busy cycles total with a single one-cycle ready/done blip between frames.
5. in=8'hFF; clr pulsed low during data bit 3 ->
   - tx=1, ready=1, busy=0 immediately (before the next edge);
   - no done pulse;
   - a fresh load of 8'h81 after release transmits a complete, correct frame.
6. CLKS_PER_BIT=1, in=8'h01 -> tx sequence 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; busy=10 cycles.
